// File: rtl/instr_fetch.sv
// Instruction fetch unit: three-state IDLE/REQ/VALID handshake with instruction memory.
// Optional fetch-timeout detector enabled by defining IFETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] NextPC,
  output logic [29:0] PC,
  output logic        imemReq,
  output logic [29:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr,
  output logic [25:0] jta,
  output logic        instrValid,
  output logic        fetchErr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0] state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      instr      <= 32'h0;
      instrValid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // Flush wins over a same-cycle ack; the returned word is dropped.
          if (flush) begin
            PC         <= NextPC;
            instrValid <= 1'b0;
          end else if (imemAck) begin
            instr      <= imemData;
            instrValid <= 1'b1;
            state      <= VALID;
          end
        end
        VALID: begin
          if (flush || !stall) begin
            PC         <= NextPC;
            instrValid <= 1'b0;
            state      <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imemReq  = (state == REQ);
  assign imemAddr = PC;
  assign jta      = instr[25:0];

`ifdef IFETCH_TIMEOUT_EN
  logic [3:0] toCnt;

  // Counts consecutive unanswered REQ cycles; the 16th raises a one-cycle error
  // and the request keeps going at the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      toCnt    <= 4'd0;
      fetchErr <= 1'b0;
    end else begin
      fetchErr <= 1'b0;
      if (state != REQ || flush || imemAck) begin
        toCnt <= 4'd0;
      end else if (toCnt == 4'd15) begin
        toCnt    <= 4'd0;
        fetchErr <= 1'b1;
      end else begin
        toCnt <= toCnt + 4'd1;
      end
    end
  end
`else
  assign fetchErr = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed-vector bench for instr_fetch (RESET_PC = 0x100); expected values are hand-computed.
// Timeout checks follow IFETCH_TIMEOUT_EN the same way the design does.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] NextPC;
  logic [29:0] PC;
  logic        imemReq;
  logic [29:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [25:0] jta;
  logic        instrValid;
  logic        fetchErr;

  int nVec = 0;
  int nMis = 0;

  instr_fetch #(.RESET_PC(30'h100)) dut (
    .clk(clk), .reset(reset), .NextPC(NextPC), .PC(PC),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
    .imemData(imemData), .stall(stall), .flush(flush), .instr(instr),
    .jta(jta), .instrValid(instrValid), .fetchErr(fetchErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then let outputs settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".pc"},    {2'b0, PC},         32'h100);
    check({tag, ".req"},   {31'b0, imemReq},   32'h0);
    check({tag, ".valid"}, {31'b0, instrValid},32'h0);
    check({tag, ".instr"}, instr,              32'h0);
    check({tag, ".jta"},   {6'b0, jta},        32'h0);
    check({tag, ".err"},   {31'b0, fetchErr},  32'h0);
  endtask

  initial begin
    reset = 1'b1; imemAck = 1'b1; imemData = 32'h1111_0001;
    stall = 1'b0; flush = 1'b0; NextPC = 30'h101;
    step(); step();
    checkResetState("rst");
    reset = 1'b0;

    // Back-to-back fetch with ack tied high: IDLE once, then valid every 2 cycles.
    step();
    check("idle2req.req",  {31'b0, imemReq},  32'h1);
    check("idle2req.addr", {2'b0, imemAddr},  32'h100);
    check("idle2req.valid",{31'b0, instrValid},32'h0);
    step();
    check("fetch0.valid", {31'b0, instrValid}, 32'h1);
    check("fetch0.instr", instr,               32'h1111_0001);
    check("fetch0.req",   {31'b0, imemReq},    32'h0);
    imemData = 32'h2222_0002;
    step();
    check("adv0.pc",    {2'b0, PC},          32'h101);
    check("adv0.valid", {31'b0, instrValid}, 32'h0);
    NextPC = 30'h102;
    step();
    check("fetch1.instr", instr, 32'h2222_0002);
    step();
    check("adv1.pc", {2'b0, PC}, 32'h102);

    // Ack arrives after 3 wait cycles: request held 4 cycles at a stable address.
    imemAck = 1'b0; imemData = 32'h0800_0040;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait.req",  {31'b0, imemReq}, 32'h1);
      check("wait.addr", {2'b0, imemAddr}, 32'h102);
    end
    imemAck = 1'b1;
    step();
    check("late.instr", instr,               32'h0800_0040);
    check("late.jta",   {6'b0, jta},         32'h0000_0040);
    check("late.valid", {31'b0, instrValid}, 32'h1);

    // Stall in VALID for 5 cycles; a stray ack must be ignored.
    stall = 1'b1; NextPC = 30'h103; imemData = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall.pc",    {2'b0, PC},          32'h102);
      check("stall.instr", instr,               32'h0800_0040);
      check("stall.valid", {31'b0, instrValid}, 32'h1);
    end
    stall = 1'b0;
    step();
    check("unstall.pc",    {2'b0, PC},          32'h103);
    check("unstall.valid", {31'b0, instrValid}, 32'h0);

    // Flush in REQ with a simultaneous ack: ack discarded, redirect to 0x2000.
    flush = 1'b1; imemAck = 1'b1; imemData = 32'h3333_3333; NextPC = 30'h2000;
    step();
    check("flushReq.pc",    {2'b0, PC},          32'h2000);
    check("flushReq.instr", instr,               32'h0800_0040);
    check("flushReq.valid", {31'b0, instrValid}, 32'h0);
    check("flushReq.req",   {31'b0, imemReq},    32'h1);
    check("flushReq.addr",  {2'b0, imemAddr},    32'h2000);
    flush = 1'b0; imemData = 32'h4444_0004;
    step();
    check("postFlush.instr", instr, 32'h4444_0004);

    // Flush overrides stall in VALID; then PC wraps from the top of the space.
    flush = 1'b1; stall = 1'b1; NextPC = 30'h3FFF_FFFF;
    step();
    check("flushValid.pc",    {2'b0, PC},          32'h3FFF_FFFF);
    check("flushValid.valid", {31'b0, instrValid}, 32'h0);
    check("flushValid.req",   {31'b0, imemReq},    32'h1);
    flush = 1'b0; stall = 1'b0; imemData = 32'h5555_0005; NextPC = 30'h0;
    step();
    check("wrapFetch.instr", instr, 32'h5555_0005);
    step();
    check("wrap.pc", {2'b0, PC}, 32'h0);

    // Memory never answers: timeout pulse on every 16th REQ cycle when enabled.
    imemAck = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      logic expErr;
`ifdef IFETCH_TIMEOUT_EN
      expErr = (k % 16 == 0);
`else
      expErr = 1'b0;
`endif
      step();
      check($sformatf("timeout%0d.err", k), {31'b0, fetchErr}, {31'b0, expErr});
      check("timeout.addr", {2'b0, imemAddr}, 32'h0);
    end

    // Reset during REQ, with an ack present that must be overridden.
    reset = 1'b1; imemAck = 1'b1; imemData = 32'h6666_0006; NextPC = 30'h77;
    step();
    checkResetState("rstReq");

    // Reset during a stalled VALID.
    reset = 1'b0;
    step();
    step();
    check("preRst.valid", {31'b0, instrValid}, 32'h1);
    check("preRst.instr", instr,               32'h6666_0006);
    stall = 1'b1; reset = 1'b1;
    step();
    checkResetState("rstValid");

    // Flush in IDLE is ignored: PC stays at the reset value.
    reset = 1'b0; stall = 1'b0; imemAck = 1'b0; flush = 1'b1; NextPC = 30'h55;
    step();
    check("flushIdle.pc",  {2'b0, PC},       32'h100);
    check("flushIdle.req", {31'b0, imemReq}, 32'h1);
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 30'h0, word address loaded into PC on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 NextPC  input  30  next word address computed by NextAddr from the current PC.
REQ-005 PC  output  30  registered current word address; feeds NextAddr.PC.
REQ-006 imemReq  output  1  instruction-memory request; combinational from state.
REQ-007 imemAddr  output  30  fetch address; equals PC at all times.
REQ-008 imemAck  input  1  memory response valid; qualifies imemData.
REQ-009 imemData  input  32  instruction word returned by memory.
REQ-010 stall  input  1  downstream hold; freezes PC and instr while in VALID.
REQ-011 flush  input  1  redirect; abandons the current fetch and loads NextPC.
REQ-012 instr  output  32  registered instruction word.
REQ-013 jta  output  26  instr[25:0], jump target field routed to NextAddr.jta.
REQ-014 instrValid  output  1  instr holds a fetched, not-yet-consumed word.
REQ-015 fetchErr  output  1  one-cycle fetch-timeout pulse (see Configuration).

Function
REQ-016 FSM SHALL have three states: IDLE, REQ, VALID; encoding is free.
REQ-017 IDLE: imemReq=0, instrValid=0; next state SHALL be REQ unconditionally.
REQ-018 REQ: imemReq=1, imemAddr=PC held stable; on imemAck=1 the block SHALL capture instr<=imemData, set instrValid<=1, go to VALID; else stay in REQ.
REQ-019 Minimum latency: entering REQ with imemAck=1 in the same cycle SHALL give instrValid=1 on the next cycle.
REQ-020 VALID with stall=0: PC<=NextPC, instrValid<=0, next state REQ; peak throughput is one instruction per 2 cycles.
REQ-021 VALID with stall=1: PC, instr, instrValid held; remain in VALID for any number of cycles.
REQ-022 flush=1 in REQ or VALID SHALL set PC<=NextPC, instrValid<=0, next state REQ; flush overrides stall and imemAck (an ack in the same cycle is discarded; instr unchanged).
REQ-023 flush=1 in IDLE SHALL be ignored.
REQ-024 imemAck while not in REQ SHALL be ignored.
REQ-025 PC arithmetic is 30-bit; PC SHALL take NextPC verbatim, including wrap from 30'h3FFFFFFF to 0.
REQ-026 jta SHALL be a pure slice of instr; no other combinational path from inputs to outputs except imemAddr=PC and imemReq=f(state).

Reset
REQ-027 reset=1 at a rising edge SHALL set state=IDLE, PC=RESET_PC, instr=32'h0, instrValid=0, fetchErr=0, timeout counter=0, overriding all other inputs.
REQ-028 Reset asserted mid-fetch SHALL abandon the request; imemReq=0 in the following cycle.

Configuration
REQ-029 Macro IFETCH_TIMEOUT_EN: when defined, a 4-bit counter SHALL count consecutive REQ cycles without imemAck; at count 15 fetchErr SHALL pulse high for one cycle, the counter SHALL clear, and REQ SHALL continue with the same address.
REQ-030 The counter SHALL clear on leaving REQ, on flush, and on imemAck.
REQ-031 When IFETCH_TIMEOUT_EN is undefined, fetchErr SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-032 RESET_PC=30'h100, reset 2 cycles, imemAck tied 1 -> IDLE one cycle, then instrValid pulses every 2 cycles, PC follows NextPC=PC+1: 0x100, 0x101, 0x102.
REQ-033 imemAck delayed 3 cycles, imemData=32'h0800_0040 -> imemReq high 4 cycles, imemAddr stable, instr=32'h0800_0040, jta=26'h000_0040.
REQ-034 stall=1 for 5 cycles in VALID -> PC, instr, instrValid=1 unchanged; on release PC<=NextPC next edge.
REQ-035 flush=1 with imemAck=1 same cycle, NextPC=30'h2000 -> instr unchanged, instrValid=0, PC=30'h2000, new REQ to 0x2000.
REQ-036 IFETCH_TIMEOUT_EN defined, imemAck held 0 -> fetchErr one-cycle pulse every 16 REQ cycles, imemAddr unchanged; undefined -> fetchErr stays 0.
REQ-037 reset asserted in REQ and in VALID with stall=1 -> next cycle all outputs at REQ-027 values, imemReq=0.
